// File: rtl/if_fetch.sv
// Instruction-fetch stage: next-PC selection, IF/ID pipeline registers and a
// 2-bit saturating-counter branch history table feeding decode's prediction.
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BHT_IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_nxt,
    input  logic        stall_IF,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        bht_upd_en,
    input  logic [31:0] bht_upd_pc,
    input  logic        bht_upd_taken,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_IF,
    output logic [31:0] pc_4_IF,
    output logic [31:0] ir_IF,
    output logic        predict
);

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          BHT_N = 1 << BHT_IDX_W;

    logic                 boot;
    logic                 advance;
    logic [1:0]           bht [BHT_N];
    logic [BHT_IDX_W-1:0] fetch_idx;
    logic [BHT_IDX_W-1:0] upd_idx;
    logic [1:0]           upd_cnt;
    logic                 unused_bits;

    // NOTE: every path assigns imem_addr, so this stays pure combinational logic (no latch).
    always_comb begin
        if (redirect_en) begin
            imem_addr = redirect_pc;
        end else if (stall_IF) begin
            imem_addr = pc_IF;
        end else if (boot) begin
            imem_addr = pc_4_IF;
        end else begin
            imem_addr = pc_nxt;
        end
    end

    assign advance   = ~stall_IF | redirect_en;
    assign fetch_idx = imem_addr[BHT_IDX_W+1:2];
    assign upd_idx   = bht_upd_pc[BHT_IDX_W+1:2];
    assign upd_cnt   = bht[upd_idx];

    // Until the first memory word returns, decode sees a NOP and forwards RESET_PC.
    assign ir_IF = boot ? NOP : imem_rdata;

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_IF   <= RESET_PC - 32'd4;
            pc_4_IF <= RESET_PC;
            predict <= 1'b0;
            boot    <= 1'b1;
        end else if (advance) begin
            pc_IF   <= imem_addr;
            pc_4_IF <= imem_addr + 32'd4;
            predict <= bht[fetch_idx][1];
            boot    <= 1'b0;
        end
    end

    // NOTE: the BHT is a flop array, not a RAM, so every entry can be reset to weakly-not-taken.
    // The lookup above reads the pre-edge counter, so a same-edge update is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bht <= '{default: 2'b01};
        end else if (bht_upd_en) begin
            if (bht_upd_taken && upd_cnt != 2'b11) begin
                bht[upd_idx] <= upd_cnt + 2'd1;
            end else if (!bht_upd_taken && upd_cnt != 2'b00) begin
                bht[upd_idx] <= upd_cnt - 2'd1;
            end
        end
    end

    assign unused_bits = ^{bht_upd_pc[31:BHT_IDX_W+2], bht_upd_pc[1:0]};

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus randomized traffic
// compared against a behavioural fetch/BHT model.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          BW       = 6;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_nxt;
    logic        stall_IF;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        bht_upd_en;
    logic [31:0] bht_upd_pc;
    logic        bht_upd_taken;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc_IF;
    logic [31:0] pc_4_IF;
    logic [31:0] ir_IF;
    logic        predict;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_pc4;
    logic        m_pred, m_boot;
    int          m_bht [1 << BW];

    if_fetch #(.RESET_PC(RESET_PC), .BHT_IDX_W(BW)) dut (
        .clk(clk), .rst(rst), .pc_nxt(pc_nxt), .stall_IF(stall_IF),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .bht_upd_en(bht_upd_en), .bht_upd_pc(bht_upd_pc), .bht_upd_taken(bht_upd_taken),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .pc_IF(pc_IF), .pc_4_IF(pc_4_IF), .ir_IF(ir_IF), .predict(predict)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ NOP;
    endfunction

    // Synchronous-read instruction memory
    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    function automatic void model_reset();
        m_pc   = RESET_PC - 32'd4;
        m_pc4  = RESET_PC;
        m_pred = 1'b0;
        m_boot = 1'b1;
        foreach (m_bht[i]) m_bht[i] = 1;
    endfunction

    function automatic logic [31:0] model_addr();
        if (redirect_en) return redirect_pc;
        if (stall_IF) return m_pc;
        if (m_boot) return m_pc4;
        return pc_nxt;
    endfunction

    function automatic logic [31:0] model_ir();
        return m_boot ? NOP : mem_word(m_pc);
    endfunction

    // One clock edge: DUT and model both advance using the inputs currently applied.
    task automatic tick();
        logic [31:0] a;
        int          u;
        a = model_addr();
        @(posedge clk);
        if (!stall_IF || redirect_en) begin
            m_pred = (m_bht[a[BW+1:2]] >= 2);
            m_pc   = a;
            m_pc4  = a + 32'd4;
            m_boot = 1'b0;
        end
        if (bht_upd_en) begin
            u = int'(bht_upd_pc[BW+1:2]);
            if (bht_upd_taken) m_bht[u] = (m_bht[u] == 3) ? 3 : m_bht[u] + 1;
            else               m_bht[u] = (m_bht[u] == 0) ? 0 : m_bht[u] - 1;
        end
        #1;
    endtask

    task automatic drive(input logic [31:0] nxt, input logic upd, input logic taken,
                         input logic [31:0] upc);
        pc_nxt        = nxt;
        stall_IF      = 1'b0;
        redirect_en   = 1'b0;
        bht_upd_en    = upd;
        bht_upd_taken = taken;
        bht_upd_pc    = upc;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_nxt = '0; stall_IF = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        bht_upd_en = 1'b0; bht_upd_pc = '0; bht_upd_taken = 1'b0;
        model_reset();
        #13;
        n_vec++; if (pc_IF !== 32'hFC) begin n_err++; $display("FAIL reset_pc: got %h exp %h", pc_IF, 32'hFC); end
        n_vec++; if (pc_4_IF !== RESET_PC) begin n_err++; $display("FAIL reset_pc4: got %h exp %h", pc_4_IF, RESET_PC); end
        n_vec++; if (ir_IF !== NOP) begin n_err++; $display("FAIL reset_ir: got %h exp %h", ir_IF, NOP); end
        n_vec++; if (predict !== 1'b0) begin n_err++; $display("FAIL reset_predict: got %b exp 0", predict); end
        n_vec++; if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL reset_addr: got %h exp %h", imem_addr, RESET_PC); end
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic test_run();
        logic [31:0] exp_pc [3] = '{32'h100, 32'h104, 32'h108};
        for (int i = 0; i < 3; i++) begin
            drive(m_pc4, 1'b0, 1'b0, '0);
            n_vec++; if (pc_IF !== exp_pc[i]) begin n_err++; $display("FAIL run_pc%0d: got %h exp %h", i, pc_IF, exp_pc[i]); end
            n_vec++; if (ir_IF !== model_ir()) begin n_err++; $display("FAIL run_ir%0d: got %h exp %h", i, ir_IF, model_ir()); end
            n_vec++; if (pc_4_IF !== exp_pc[i] + 32'd4) begin n_err++; $display("FAIL run_pc4_%0d: got %h exp %h", i, pc_4_IF, exp_pc[i] + 32'd4); end
        end
    endtask

    task automatic test_stall();
        pc_nxt = 32'h300; stall_IF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (imem_addr !== 32'h108) begin n_err++; $display("FAIL stall_addr%0d: got %h exp %h", i, imem_addr, 32'h108); end
            tick();
            n_vec++; if (pc_IF !== 32'h108) begin n_err++; $display("FAIL stall_pc%0d: got %h exp %h", i, pc_IF, 32'h108); end
            n_vec++; if (ir_IF !== mem_word(32'h108)) begin n_err++; $display("FAIL stall_ir%0d: got %h exp %h", i, ir_IF, mem_word(32'h108)); end
            n_vec++; if (predict !== m_pred) begin n_err++; $display("FAIL stall_pred%0d: got %b exp %b", i, predict, m_pred); end
        end
        drive(32'h10C, 1'b0, 1'b0, '0);
        n_vec++; if (pc_IF !== 32'h10C) begin n_err++; $display("FAIL stall_release: got %h exp %h", pc_IF, 32'h10C); end
    endtask

    task automatic test_redirect_over_stall();
        pc_nxt = 32'h400; stall_IF = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h200;
        #1;
        n_vec++; if (imem_addr !== 32'h200) begin n_err++; $display("FAIL redir_addr: got %h exp %h", imem_addr, 32'h200); end
        tick();
        n_vec++; if (pc_IF !== 32'h200) begin n_err++; $display("FAIL redir_pc: got %h exp %h", pc_IF, 32'h200); end
        n_vec++; if (pc_4_IF !== 32'h204) begin n_err++; $display("FAIL redir_pc4: got %h exp %h", pc_4_IF, 32'h204); end
        n_vec++; if (ir_IF !== mem_word(32'h200)) begin n_err++; $display("FAIL redir_ir: got %h exp %h", ir_IF, mem_word(32'h200)); end
        stall_IF = 1'b0; redirect_en = 1'b0;
    endtask

    task automatic test_bht_saturation();
        for (int i = 0; i < 4; i++) drive(32'h80, 1'b1, 1'b1, 32'h40);
        drive(32'h40, 1'b0, 1'b0, '0);
        n_vec++; if (predict !== 1'b1) begin n_err++; $display("FAIL sat_hi: got %b exp 1", predict); end
        drive(32'h84, 1'b1, 1'b0, 32'h40);
        drive(32'h40, 1'b0, 1'b0, '0);
        n_vec++; if (predict !== 1'b1) begin n_err++; $display("FAIL sat_hi_dec: got %b exp 1", predict); end
        for (int i = 0; i < 4; i++) drive(32'h88, 1'b1, 1'b0, 32'h40);
        drive(32'h40, 1'b0, 1'b0, '0);
        n_vec++; if (predict !== 1'b0) begin n_err++; $display("FAIL sat_lo: got %b exp 0", predict); end
        for (int i = 0; i < 2; i++) drive(32'h8C, 1'b1, 1'b1, 32'h40);
        drive(32'h40, 1'b0, 1'b0, '0);
        n_vec++; if (predict !== m_pred) begin n_err++; $display("FAIL sat_lo_inc: got %b exp %b", predict, m_pred); end
        n_vec++; if (predict !== 1'b1) begin n_err++; $display("FAIL sat_lo_inc_const: got %b exp 1", predict); end
    endtask

    task automatic test_wrap_and_reset();
        drive(32'hFFFF_FFFC, 1'b1, 1'b1, 32'h40);
        n_vec++; if (pc_IF !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc: got %h exp %h", pc_IF, 32'hFFFF_FFFC); end
        n_vec++; if (pc_4_IF !== 32'h0) begin n_err++; $display("FAIL wrap_pc4: got %h exp %h", pc_4_IF, 32'h0); end
        drive(32'h40, 1'b0, 1'b0, '0);
        n_vec++; if (predict !== 1'b1) begin n_err++; $display("FAIL prereset_pred: got %b exp 1", predict); end
        stall_IF = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h500;
        #1 rst = 1'b1;
        model_reset();
        #1;
        n_vec++; if (pc_IF !== 32'hFC) begin n_err++; $display("FAIL midrst_pc: got %h exp %h", pc_IF, 32'hFC); end
        n_vec++; if (pc_4_IF !== RESET_PC) begin n_err++; $display("FAIL midrst_pc4: got %h exp %h", pc_4_IF, RESET_PC); end
        n_vec++; if (ir_IF !== NOP) begin n_err++; $display("FAIL midrst_ir: got %h exp %h", ir_IF, NOP); end
        n_vec++; if (predict !== 1'b0) begin n_err++; $display("FAIL midrst_pred: got %b exp 0", predict); end
        stall_IF = 1'b0; redirect_en = 1'b0;
        #1;
        n_vec++; if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL midrst_addr: got %h exp %h", imem_addr, RESET_PC); end
        #1 rst = 1'b0;
        drive(32'h900, 1'b0, 1'b0, '0);
        n_vec++; if (pc_IF !== RESET_PC) begin n_err++; $display("FAIL postrst_pc: got %h exp %h", pc_IF, RESET_PC); end
        drive(32'h40, 1'b0, 1'b0, '0);
        n_vec++; if (predict !== 1'b0) begin n_err++; $display("FAIL postrst_bht: got %b exp 0", predict); end
    endtask

    task automatic test_collision();
        drive(32'h40, 1'b1, 1'b1, 32'h40);
        n_vec++; if (predict !== 1'b0) begin n_err++; $display("FAIL coll_same_edge: got %b exp 0", predict); end
        drive(32'h40, 1'b0, 1'b0, '0);
        n_vec++; if (predict !== 1'b1) begin n_err++; $display("FAIL coll_refetch: got %b exp 1", predict); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 400; i++) begin
            pc_nxt        = ($urandom_range(0, 15) == 0) ? $urandom : {24'h0, 6'($urandom), 2'b00};
            stall_IF      = ($urandom_range(0, 3) == 0);
            redirect_en   = ($urandom_range(0, 7) == 0);
            redirect_pc   = {24'h0, 6'($urandom), 2'b00};
            bht_upd_en    = ($urandom_range(0, 1) == 0);
            bht_upd_pc    = {24'h0, 2'($urandom), 4'($urandom), 2'b00};
            bht_upd_taken = ($urandom_range(0, 2) != 0) ^ bht_upd_pc[2];
            #1;
            a = model_addr();
            n_vec++; if (imem_addr !== a) begin n_err++; $display("FAIL rnd_addr[%0d]: got %h exp %h", i, imem_addr, a); end
            tick();
            n_vec++; if (pc_IF !== m_pc) begin n_err++; $display("FAIL rnd_pc[%0d]: got %h exp %h", i, pc_IF, m_pc); end
            n_vec++; if (pc_4_IF !== m_pc4) begin n_err++; $display("FAIL rnd_pc4[%0d]: got %h exp %h", i, pc_4_IF, m_pc4); end
            n_vec++; if (ir_IF !== model_ir()) begin n_err++; $display("FAIL rnd_ir[%0d]: got %h exp %h", i, ir_IF, model_ir()); end
            n_vec++; if (predict !== m_pred) begin n_err++; $display("FAIL rnd_pred[%0d]: got %b exp %b", i, predict, m_pred); end
        end
        stall_IF = 1'b0; redirect_en = 1'b0; bht_upd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run();
        test_stall();
        test_redirect_over_stall();
        test_bht_saturation();
        test_wrap_and_reset();
        test_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
